// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory arbiter: FSM encoding,
// default timeout, grant vector layout and the alignment helper.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int unsigned TIMEOUT_DEF = 15;
    localparam int unsigned WAIT_W      = 8;

    // One-hot grant vector: bit 0 = fetch, bit 1 = loader
    localparam int unsigned G_FETCH = 0;
    localparam int unsigned G_LOAD  = 1;

    localparam logic [1:0] GNT_NONE  = 2'b00;
    localparam logic [1:0] GNT_FETCH = 2'b01;
    localparam logic [1:0] GNT_LOAD  = 2'b10;

    function automatic logic is_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Bundle of fetch, loader and shared memory port signals. The slave modport
// is the arbiter's view; the master modport is the requesters plus memory.
interface imem_arbiter_if #(
    parameter int unsigned ADDR_W = 32
) ();

    logic              f_valid;
    logic [ADDR_W-1:0] f_addr;
    logic              f_ready;
    logic [31:0]       f_rdata;
    logic              f_err;

    logic              l_valid;
    logic [ADDR_W-1:0] l_addr;
    logic [7:0]        l_wdata;
    logic              l_ready;
    logic              l_err;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport slave (
        input  f_valid, f_addr,
        output f_ready, f_rdata, f_err,
        input  l_valid, l_addr, l_wdata,
        output l_ready, l_err,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport master (
        output f_valid, f_addr,
        input  f_ready, f_rdata, f_err,
        output l_valid, l_addr, l_wdata,
        input  l_ready, l_err,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/imem_arb_pick.sv
// Combinational grant decision between fetch and loader.
// IMEM_ARB_RR_EN selects round-robin on ties; otherwise the loader always wins.
module imem_arb_pick
    import imem_pkg::*;
(
    input  logic       i_f_valid,
    input  logic       i_l_valid,
    input  logic       i_last_load,
    output logic [1:0] o_grant
);

`ifdef IMEM_ARB_RR_EN
    always_comb begin
        o_grant = GNT_NONE;
        if (i_f_valid && i_l_valid) begin
            o_grant = i_last_load ? GNT_FETCH : GNT_LOAD;
        end else if (i_l_valid) begin
            o_grant = GNT_LOAD;
        end else if (i_f_valid) begin
            o_grant = GNT_FETCH;
        end
    end
`else
    logic w_unused_last;
    assign w_unused_last = i_last_load;

    always_comb begin
        o_grant = GNT_NONE;
        if (i_l_valid) begin
            o_grant = GNT_LOAD;
        end else if (i_f_valid) begin
            o_grant = GNT_FETCH;
        end
    end
`endif

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates instruction fetch reads and loader byte writes onto one memory
// port with a wait-cycle timeout. Optional macro IMEM_ARB_RR_EN: round-robin.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic           clk,
    input  logic           rst,
    imem_arbiter_if.slave  bus
);

    localparam logic [WAIT_W-1:0] LP_LIMIT = 8'(TIMEOUT - 32'd1);

    state_e              r_state;
    state_e              w_state_nx;

    logic [WAIT_W-1:0]   r_wait;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_wdata;
    logic [31:0]         r_rdata;
    logic                r_owner_load;
    logic                r_err;

    logic [1:0]          w_grant;
    logic                w_capture;
    logic                w_misalign;
    logic                w_busy;
    logic                w_limit;

    logic                w_mem_req;
    logic                w_mem_we;
    logic                w_f_ready;
    logic                w_f_err;
    logic                w_l_ready;
    logic                w_l_err;

    // The owner register routes the response and doubles as the last-grant input
    imem_arb_pick u_pick (
        .i_f_valid   (bus.f_valid),
        .i_l_valid   (bus.l_valid),
        .i_last_load (r_owner_load),
        .o_grant     (w_grant)
    );

    assign w_misalign = !is_aligned(bus.f_addr[1:0]);
    assign w_busy     = (r_state == FETCH) || (r_state == LOAD);
    assign w_limit    = (r_wait == LP_LIMIT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_capture  = 1'b0;
        w_mem_req  = 1'b0;
        w_mem_we   = 1'b0;
        w_f_ready  = 1'b0;
        w_f_err    = 1'b0;
        w_l_ready  = 1'b0;
        w_l_err    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_grant[G_LOAD]) begin
                    w_capture  = 1'b1;
                    w_state_nx = LOAD;
                end else if (w_grant[G_FETCH]) begin
                    w_capture  = 1'b1;
                    w_state_nx = w_misalign ? RESP : FETCH;
                end
            end
            FETCH, LOAD: begin
                w_mem_req = 1'b1;
                w_mem_we  = (r_state == LOAD);
                if (bus.mem_ack || w_limit) begin
                    w_state_nx = RESP;
                end
            end
            RESP: begin
                w_f_ready  = !r_owner_load;
                w_f_err    = !r_owner_load && r_err;
                w_l_ready  = r_owner_load;
                w_l_err    = r_owner_load && r_err;
                w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Ack is checked before the limit so a same-cycle ack clears the error
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wait       <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_owner_load <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_capture) begin
                r_wait       <= '0;
                r_owner_load <= w_grant[G_LOAD];
                if (w_grant[G_LOAD]) begin
                    r_addr  <= bus.l_addr;
                    r_wdata <= bus.l_wdata;
                    r_err   <= 1'b0;
                end else begin
                    r_addr  <= bus.f_addr;
                    r_err   <= w_misalign;
                end
            end
            if (w_busy) begin
                if (bus.mem_ack) begin
                    r_err <= 1'b0;
                    if (r_state == FETCH) begin
                        r_rdata <= bus.mem_rdata;
                    end
                end else begin
                    r_wait <= r_wait + 8'd1;
                    if (w_limit) begin
                        r_err <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.mem_req   = w_mem_req;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.f_ready   = w_f_ready;
    assign bus.f_err     = w_f_err;
    assign bus.f_rdata   = r_rdata;
    assign bus.l_ready   = w_l_ready;
    assign bus.l_err     = w_l_err;

    a_we_needs_req: assert property (@(posedge clk) disable iff (!rst)
        bus.mem_we |-> bus.mem_req);

    a_ready_exclusive: assert property (@(posedge clk) disable iff (!rst)
        !(bus.f_ready && bus.l_ready));

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: inputs driven and outputs sampled on the
// falling edge; control outputs compared as {req, we, f_ready, f_err, l_ready, l_err}.
module tb_imem_arbiter;
    import imem_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    imem_arbiter_if #(.ADDR_W(32)) bus ();

    imem_arbiter #(
        .ADDR_W  (32),
        .TIMEOUT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] ctl();
        return {bus.mem_req, bus.mem_we, bus.f_ready, bus.f_err, bus.l_ready, bus.l_err};
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ctl() !== 6'b000000) begin
            errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl(), 6'b000000);
        end
        checks++;
        if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 8'h0) begin
            errors++; $display("FAIL reset_bus got=%h/%h exp=0/0", bus.mem_addr, bus.mem_wdata);
        end
        checks++;
        if (bus.f_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata got=%h exp=%h", bus.f_rdata, 32'h0);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        bus.f_valid = 1'b1; bus.f_addr = 32'h4;
        @(negedge clk);
        checks++;
        if (ctl() !== 6'b100000 || bus.mem_addr !== 32'h4) begin
            errors++; $display("FAIL fetch_grant got=%b/%h exp=100000/4", ctl(), bus.mem_addr);
        end
        @(negedge clk);
        checks++;
        if (ctl() !== 6'b100000) begin
            errors++; $display("FAIL fetch_wait got=%b exp=100000", ctl());
        end
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h00600393;
        @(negedge clk);
        checks++;
        if (ctl() !== 6'b001000) begin
            errors++; $display("FAIL fetch_resp got=%b exp=001000", ctl());
        end
        checks++;
        if (bus.f_rdata !== 32'h00600393) begin
            errors++; $display("FAIL fetch_rdata got=%h exp=%h", bus.f_rdata, 32'h00600393);
        end
        bus.f_valid = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        @(negedge clk);
        checks++;
        if (ctl() !== 6'b000000 || bus.f_rdata !== 32'h00600393) begin
            errors++; $display("FAIL fetch_after got=%b/%h exp=000000/00600393", ctl(), bus.f_rdata);
        end
    endtask

    task automatic test_collision(input logic [31:0] rd);
        bus.f_valid = 1'b1; bus.f_addr  = 32'h10;
        bus.l_valid = 1'b1; bus.l_addr  = 32'h8; bus.l_wdata = 8'h33;
        @(negedge clk);
        checks++;
        if (ctl() !== 6'b110000 || bus.mem_addr !== 32'h8 || bus.mem_wdata !== 8'h33) begin
            errors++; $display("FAIL coll_load got=%b/%h/%h exp=110000/8/33", ctl(), bus.mem_addr, bus.mem_wdata);
        end
        bus.mem_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl() !== 6'b000010) begin
            errors++; $display("FAIL coll_l_ready got=%b exp=000010", ctl());
        end
        bus.l_valid = 1'b0; bus.mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl() !== 6'b000000) begin
            errors++; $display("FAIL coll_idle got=%b exp=000000", ctl());
        end
        @(negedge clk);
        checks++;
        if (ctl() !== 6'b100000 || bus.mem_addr !== 32'h10) begin
            errors++; $display("FAIL coll_fetch got=%b/%h exp=100000/10", ctl(), bus.mem_addr);
        end
        bus.mem_ack = 1'b1; bus.mem_rdata = rd;
        @(negedge clk);
        checks++;
        if (ctl() !== 6'b001000 || bus.f_rdata !== rd) begin
            errors++; $display("FAIL coll_f_ready got=%b/%h exp=001000/%h", ctl(), bus.f_rdata, rd);
        end
        bus.f_valid = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        @(negedge clk);
    endtask

    task automatic test_misaligned(input logic [31:0] prev);
        bus.f_valid = 1'b1; bus.f_addr = 32'h6;
        @(negedge clk);
        checks++;
        if (ctl() !== 6'b001100) begin
            errors++; $display("FAIL mis_resp got=%b exp=001100", ctl());
        end
        checks++;
        if (bus.f_rdata !== prev) begin
            errors++; $display("FAIL mis_rdata got=%h exp=%h", bus.f_rdata, prev);
        end
        bus.f_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl() !== 6'b000000) begin
            errors++; $display("FAIL mis_after got=%b exp=000000", ctl());
        end
    endtask

    task automatic test_ack_ignored(input logic [31:0] prev);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if (ctl() !== 6'b000000 || bus.f_rdata !== prev) begin
            errors++; $display("FAIL stray_ack got=%b/%h exp=000000/%h", ctl(), bus.f_rdata, prev);
        end
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        bus.l_valid = 1'b1; bus.l_addr = 32'h20; bus.l_wdata = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (ctl() !== 6'b110000) begin
                errors++; $display("FAIL to_wait%0d got=%b exp=110000", i, ctl());
            end
        end
        @(negedge clk);
        checks++;
        if (ctl() !== 6'b000011) begin
            errors++; $display("FAIL to_resp got=%b exp=000011", ctl());
        end
        bus.l_valid = 1'b0;
        @(negedge clk);
        // Next fetch with same-cycle ack: minimum-latency path
        bus.f_valid = 1'b1; bus.f_addr = 32'h0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h11223344;
        @(negedge clk);
        checks++;
        if (ctl() !== 6'b100000) begin
            errors++; $display("FAIL to_next_grant got=%b exp=100000", ctl());
        end
        @(negedge clk);
        checks++;
        if (ctl() !== 6'b001000 || bus.f_rdata !== 32'h11223344) begin
            errors++; $display("FAIL to_next_resp got=%b/%h exp=001000/11223344", ctl(), bus.f_rdata);
        end
        bus.f_valid = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        @(negedge clk);
    endtask

    task automatic test_ack_at_limit();
        bus.l_valid = 1'b1; bus.l_addr = 32'h30; bus.l_wdata = 8'hC3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (ctl() !== 6'b110000) begin
                errors++; $display("FAIL lim_wait%0d got=%b exp=110000", i, ctl());
            end
            if (i == 3) bus.mem_ack = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (ctl() !== 6'b000010) begin
            errors++; $display("FAIL lim_resp got=%b exp=000010", ctl());
        end
        bus.l_valid = 1'b0; bus.mem_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back_priority();
        logic [5:0]  exp_ctl2, exp_rdy2, exp_ctl3, exp_rdy3;
        logic [31:0] exp_addr2, exp_addr3;
        logic        second_is_load;
`ifdef IMEM_ARB_RR_EN
        second_is_load = 1'b0;
`else
        second_is_load = 1'b1;
`endif
        exp_ctl2  = second_is_load ? 6'b110000 : 6'b100000;
        exp_rdy2  = second_is_load ? 6'b000010 : 6'b001000;
        exp_addr2 = second_is_load ? 32'h54 : 32'h40;
        exp_ctl3  = second_is_load ? 6'b100000 : 6'b110000;
        exp_rdy3  = second_is_load ? 6'b001000 : 6'b000010;
        exp_addr3 = second_is_load ? 32'h40 : 32'h54;

        bus.f_valid = 1'b1; bus.f_addr = 32'h40;
        bus.l_valid = 1'b1; bus.l_addr = 32'h50; bus.l_wdata = 8'h11;
        @(negedge clk);
        checks++;
        if (ctl() !== 6'b110000 || bus.mem_addr !== 32'h50) begin
            errors++; $display("FAIL rep_first got=%b/%h exp=110000/50", ctl(), bus.mem_addr);
        end
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.l_addr = 32'h54; bus.l_wdata = 8'h22; bus.mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ctl() !== exp_ctl2 || bus.mem_addr !== exp_addr2) begin
            errors++; $display("FAIL rep_second got=%b/%h exp=%b/%h", ctl(), bus.mem_addr, exp_ctl2, exp_addr2);
        end
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BADF00D;
        @(negedge clk);
        checks++;
        if (ctl() !== exp_rdy2) begin
            errors++; $display("FAIL rep_second_rdy got=%b exp=%b", ctl(), exp_rdy2);
        end
        if (second_is_load) bus.l_valid = 1'b0; else bus.f_valid = 1'b0;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ctl() !== exp_ctl3 || bus.mem_addr !== exp_addr3) begin
            errors++; $display("FAIL rep_third got=%b/%h exp=%b/%h", ctl(), bus.mem_addr, exp_ctl3, exp_addr3);
        end
        bus.mem_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl() !== exp_rdy3) begin
            errors++; $display("FAIL rep_third_rdy got=%b exp=%b", ctl(), exp_rdy3);
        end
        bus.f_valid = 1'b0; bus.l_valid = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        @(negedge clk);
        checks++;
        if (bus.f_rdata !== 32'h0BADF00D) begin
            errors++; $display("FAIL rep_rdata got=%h exp=%h", bus.f_rdata, 32'h0BADF00D);
        end
    endtask

    task automatic test_reset_mid();
        bus.f_valid = 1'b1; bus.f_addr = 32'hC;
        @(negedge clk);
        checks++;
        if (ctl() !== 6'b100000) begin
            errors++; $display("FAIL rst_mid_fetch got=%b exp=100000", ctl());
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl() !== 6'b000000 || bus.mem_addr !== 32'h0 || bus.f_rdata !== 32'h0) begin
            errors++; $display("FAIL rst_mid got=%b/%h/%h exp=000000/0/0", ctl(), bus.mem_addr, bus.f_rdata);
        end
        bus.f_valid = 1'b0; rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (ctl() !== 6'b000000) begin
                errors++; $display("FAIL rst_no_ready%0d got=%b exp=000000", i, ctl());
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.f_valid = 1'b0; bus.f_addr = '0;
        bus.l_valid = 1'b0; bus.l_addr = '0; bus.l_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;

        test_reset();
        test_fetch();
        test_collision(32'hA5A50001);
        test_collision(32'hA5A50002);
        test_misaligned(32'hA5A50002);
        test_ack_ignored(32'hA5A50002);
        test_timeout();
        test_ack_at_limit();
        test_back_to_back_priority();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: byte-address width of all address ports.
REQ-002 Parameter TIMEOUT, default 15: max memory wait cycles before error response; range 1..255.
REQ-003 clk  input  1: rising-edge clock.
REQ-004 rst  input  1: reset, synchronous, active-low.
REQ-005 f_valid / f_addr  input  1 / ADDR_W: fetch read request and byte address.
REQ-006 f_ready / f_rdata / f_err  output  1 / 32 / 1: fetch completion pulse, word, error flag.
REQ-007 l_valid / l_addr / l_wdata  input  1 / ADDR_W / 8: loader byte-write request, address, byte.
REQ-008 l_ready / l_err  output  1 / 1: loader completion pulse, error flag.
REQ-009 mem_req / mem_we / mem_addr / mem_wdata  output  1 / 1 / ADDR_W / 8: shared memory port command.
REQ-010 mem_ack / mem_rdata  input  1 / 32: memory completion and big-endian read word {byte A, A+1, A+2, A+3}.

Function
REQ-011 The FSM SHALL have states IDLE, FETCH, LOAD, RESP.
- IDLE -> LOAD when l_valid; else -> FETCH when f_valid; else stay.
- FETCH/LOAD -> RESP on mem_ack or timeout; RESP -> IDLE unconditionally.
REQ-012 Loader SHALL have fixed priority over fetch on the same IDLE cycle.
REQ-013 mem_req SHALL be high in FETCH and LOAD only; mem_we high only in LOAD.
REQ-014 mem_addr and mem_wdata SHALL come from registers captured on the IDLE->grant edge and SHALL stay stable until RESP.
REQ-015 Requesters SHALL hold valid and payload stable until their ready pulse; the arbiter SHALL NOT depend on payload after capture.
REQ-016 The granted requester's ready SHALL pulse exactly one cycle, in RESP; the other ready SHALL stay low.
REQ-017 f_rdata SHALL be mem_rdata registered on the mem_ack cycle; held until the next fetch response.
REQ-018 A fetch with f_addr[1:0] != 0 SHALL skip memory: IDLE -> RESP directly, f_ready=1, f_err=1, f_rdata unchanged.
REQ-019 A wait-cycle counter (8 bits) SHALL clear on grant and increment each FETCH/LOAD cycle without mem_ack.
- When it reaches TIMEOUT, go to RESP with the matching err=1.
- mem_ack arriving on the same cycle as the limit SHALL win: err=0.
REQ-020 Minimum latency SHALL be 3 cycles from valid-high to ready: IDLE, grant with same-cycle ack, RESP.
REQ-021 mem_ack outside FETCH/LOAD SHALL be ignored.

Reset
REQ-022 rst low at a clock edge SHALL set state IDLE, counter 0, and all outputs 0 (f_rdata 32'h0), including mid-transaction.
- An in-flight transaction is dropped with no ready pulse.

Configuration
REQ-023 With macro IMEM_ARB_RR_EN defined, arbitration SHALL be round-robin.
- A last-grant flag decides simultaneous requests: the requester not granted last wins.
- The flag resets to "fetch", so the loader wins the first tie.
REQ-024 Without IMEM_ARB_RR_EN, REQ-012 fixed priority SHALL apply and no last-grant flag SHALL exist.

Structure
REQ-025 State encodings (IDLE=0, FETCH=1, LOAD=2, RESP=3) and the default TIMEOUT constant SHALL live in the shared package imem_pkg.
REQ-026 The arbitration decision SHALL be a sub-module imem_arb_pick.
- Inputs: f_valid, l_valid, last-grant.
- Output: one-hot grant.
- Combinational, and the only place IMEM_ARB_RR_EN is tested.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Fetch: f_valid, f_addr=0x4; memory acks 1 cycle later with 0x00600393 -> f_ready pulse one cycle, f_rdata=0x00600393, f_err=0, mem_we=0.
- Collision, fixed priority: f_valid and l_valid together, l_addr=0x8, l_wdata=0x33 -> LOAD first (mem_we=1, mem_addr=0x8, mem_wdata=0x33), then FETCH; l_ready precedes f_ready.
- Collision, IMEM_ARB_RR_EN: two back-to-back collisions -> grants loader, fetch, loader, fetch.
- Misaligned fetch: f_addr=0x6 -> no mem_req, f_ready with f_err=1 two cycles after valid.
- Timeout: TIMEOUT=4, mem_ack never asserts -> l_ready, l_err=1 after 4 LOAD cycles; next request serviced normally.
- Reset: rst low while in FETCH -> next cycle mem_req=0, state IDLE, no f_ready pulse.
